// File: rtl/usb_ls_rx_seq.sv
// Low-speed USB receive sequencer: NRZI decode, SYNC detect, bit unstuffing,
// byte assembly and EOP/error sequencing. All state advances on rx_strobe.

package types;
  // Line state as {D+, D-}; low-speed J idles with D- high.
  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } d_port_t;
endpackage

module usb_ls_rx_seq #(
  parameter int SYNC_ZEROS_MIN = 5,
  parameter int STUFF_LEN      = 6,
  parameter int IDLE_BITS      = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  types::d_port_t rx_q,
  input  logic          rx_strobe,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  output logic          rx_active,
  output logic          rx_error
);
  import types::*;

  localparam int ONES_W = $clog2(STUFF_LEN + 1);
  localparam int IDLE_W = $clog2(IDLE_BITS + 1);

  localparam logic [2:0]        SYNC_MIN  = 3'(SYNC_ZEROS_MIN);
  localparam logic [ONES_W-1:0] STUFF_AT  = ONES_W'(STUFF_LEN);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP,
    ST_ERROR
  } state_t;

  state_t              state_q;
  d_port_t             prev_q;
  logic [2:0]          zero_cnt_q;
  logic [ONES_W-1:0]   ones_cnt_q;
  logic [2:0]          bit_cnt_q;
  logic [7:0]          shift_q;
  logic [1:0]          se0_cnt_q;
  logic [IDLE_W-1:0]   j_cnt_q;
  logic [7:0]          data_q;
  logic                valid_q;
  logic                active_q;
  logic                error_q;

  logic                is_jk_d;
  d_port_t             prev_eff_d;
  logic                dec_bit_d;
  logic [7:0]          byte_d;

  // NRZI decode; in IDLE the reference is J so a leading K reads as 0.
  always_comb begin
    is_jk_d    = (rx_q == LS_J) || (rx_q == LS_K);
    prev_eff_d = (state_q == ST_IDLE) ? LS_J : prev_q;
    dec_bit_d  = (rx_q == prev_eff_d);
    byte_d     = {dec_bit_d, shift_q[7:1]};
  end

  // Receive FSM with registered outputs; pulses clear every cycle by default.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      prev_q     <= LS_J;
      zero_cnt_q <= '0;
      ones_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      se0_cnt_q  <= '0;
      j_cnt_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
      error_q    <= 1'b0;
    end else if (!enable) begin
      state_q    <= ST_IDLE;
      prev_q     <= LS_J;
      zero_cnt_q <= '0;
      ones_cnt_q <= '0;
      bit_cnt_q  <= '0;
      se0_cnt_q  <= '0;
      j_cnt_q    <= '0;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      if (rx_strobe) begin
        if (is_jk_d) begin
          prev_q <= rx_q;
        end
        if ((rx_q == LS_SE1) && (state_q != ST_IDLE)) begin
          // Illegal line state: flag once on entry, restart the idle count.
          if (state_q != ST_ERROR) begin
            error_q <= 1'b1;
          end
          state_q <= ST_ERROR;
          j_cnt_q <= '0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (rx_q == LS_K) begin
                state_q    <= ST_SYNC;
                zero_cnt_q <= 3'd1;
              end
            end
            ST_SYNC: begin
              if (rx_q == LS_SE0) begin
                state_q <= ST_ERROR;
                error_q <= 1'b1;
                j_cnt_q <= '0;
              end else if (!dec_bit_d) begin
                if (zero_cnt_q != 3'd7) begin
                  zero_cnt_q <= zero_cnt_q + 3'd1;
                end
              end else if (zero_cnt_q >= SYNC_MIN) begin
                state_q    <= ST_DATA;
                active_q   <= 1'b1;
                ones_cnt_q <= '0;
                bit_cnt_q  <= '0;
              end else begin
                state_q <= ST_ERROR;
                error_q <= 1'b1;
                j_cnt_q <= '0;
              end
            end
            ST_DATA: begin
              if (rx_q == LS_SE0) begin
                // End of packet; an unfinished byte is dropped and flagged.
                state_q   <= ST_EOP;
                se0_cnt_q <= 2'd1;
                if (bit_cnt_q != 3'd0) begin
                  error_q <= 1'b1;
                end
              end else if (ones_cnt_q == STUFF_AT) begin
                if (dec_bit_d) begin
                  state_q <= ST_ERROR;
                  error_q <= 1'b1;
                  j_cnt_q <= '0;
                end else begin
                  ones_cnt_q <= '0;
                end
              end else begin
                shift_q    <= byte_d;
                ones_cnt_q <= dec_bit_d ? ones_cnt_q + 1'b1 : '0;
                bit_cnt_q  <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                  data_q  <= byte_d;
                  valid_q <= 1'b1;
                end
              end
            end
            ST_EOP: begin
              if (rx_q == LS_SE0) begin
                if (se0_cnt_q != 2'd3) begin
                  se0_cnt_q <= se0_cnt_q + 2'd1;
                end
              end else if (rx_q == LS_J) begin
                state_q   <= ST_IDLE;
                active_q  <= 1'b0;
                se0_cnt_q <= '0;
              end else begin
                state_q <= ST_ERROR;
                error_q <= 1'b1;
                j_cnt_q <= '0;
              end
            end
            ST_ERROR: begin
              if (rx_q == LS_J) begin
                if (j_cnt_q == IDLE_LAST) begin
                  state_q  <= ST_IDLE;
                  active_q <= 1'b0;
                  prev_q   <= LS_J;
                  j_cnt_q  <= '0;
                end else begin
                  j_cnt_q <= j_cnt_q + 1'b1;
                end
              end else begin
                j_cnt_q <= '0;
              end
            end
            default: begin
              state_q <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_active = active_q;
  assign rx_error  = error_q;

endmodule

// File: tb/tb_usb_ls_rx_seq.sv
// Scoreboard bench for usb_ls_rx_seq: the driver NRZI-encodes and stuffs
// packets, pushing the expected byte/error pulses; a monitor pops and compares.

module tb_usb_ls_rx_seq;
  import types::*;

  localparam int K_NONE = 0;
  localparam int K_BYTE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  d_port_t    rx_q;
  logic       rx_strobe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_error;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  exp_t       sb_q[$];
  d_port_t    line_lvl = LS_J;
  int         ones_tb = 0;
  int         data_strobes = 0;
  logic       last_active = 1'b0;

  usb_ls_rx_seq dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .rx_q      (rx_q),
    .rx_strobe (rx_strobe),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_active (rx_active),
    .rx_error  (rx_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: every output pulse must match the oldest expected event and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rx_valid) begin
      $display("rx byte %02h at cycle %0d", rx_data, cyc);
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("valid_kind", 32'(K_BYTE), 32'(e.kind));
        chk("valid_data", 32'(rx_data), 32'(e.data));
        chk("valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (rx_error) begin
      $display("rx error at cycle %0d", cyc);
      if (sb_q.size() == 0) begin
        chk("unexpected_error", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("error_kind", 32'(K_ERR), 32'(e.kind));
        chk("error_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // One bit-time: strobe for one clk, then two idle clks.
  task automatic strobe(input d_port_t v, input int kind, input logic [7:0] d);
    exp_t e;
    rx_q      = v;
    rx_strobe = 1'b1;
    if (kind != K_NONE) begin
      e.kind = kind;
      e.data = d;
      e.cyc  = cyc + 1;
      sb_q.push_back(e);
    end
    @(negedge clk);
    rx_strobe   = 1'b0;
    last_active = rx_active;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_nrzi(input bit b, input int kind, input logic [7:0] d);
    if (!b) line_lvl = (line_lvl == LS_J) ? LS_K : LS_J;
    strobe(line_lvl, kind, d);
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) strobe(LS_J, K_NONE, 8'h00);
    line_lvl = LS_J;
  endtask

  task automatic send_sync();
    line_lvl = LS_J;
    for (int i = 0; i < 7; i++) send_nrzi(1'b0, K_NONE, 8'h00);
    chk("sync_active_early", 32'(last_active), 32'd0);
    send_nrzi(1'b1, K_NONE, 8'h00);
    chk("sync_active_rise", 32'(last_active), 32'd1);
    ones_tb = 0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (ones_tb == 6) begin
        send_nrzi(1'b0, K_NONE, 8'h00);
        data_strobes++;
        ones_tb = 0;
      end
      send_nrzi(v[i], (i == 7) ? K_BYTE : K_NONE, v);
      data_strobes++;
      ones_tb = v[i] ? ones_tb + 1 : 0;
    end
    chk("byte_active_hold", 32'(last_active), 32'd1);
  endtask

  task automatic send_eop(input bit partial);
    strobe(LS_SE0, partial ? K_ERR : K_NONE, 8'h00);
    strobe(LS_SE0, K_NONE, 8'h00);
    chk("eop_active_hold", 32'(last_active), 32'd1);
    strobe(LS_J, K_NONE, 8'h00);
    chk("eop_active_fall", 32'(last_active), 32'd0);
    line_lvl = LS_J;
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    rx_q      = LS_J;
    rx_strobe = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_data", 32'(rx_data), 32'h0);
    chk("reset_valid", 32'(rx_valid), 32'h0);
    chk("reset_active", 32'(rx_active), 32'h0);
    chk("reset_error", 32'(rx_error), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Basic packet with one byte.
    send_idle(4);
    send_sync();
    send_byte(8'hA5);
    send_eop(1'b0);

    // Stuffed 0xFF then 0x00.
    send_idle(2);
    send_sync();
    data_strobes = 0;
    send_byte(8'hFF);
    send_byte(8'h00);
    chk("stuff_data_strobes", 32'(data_strobes), 32'd17);
    send_eop(1'b0);

    // Seven decoded ones: stuff error, then idle recovery.
    send_idle(2);
    send_sync();
    for (int i = 1; i <= 7; i++) send_nrzi(1'b1, (i == 7) ? K_ERR : K_NONE, 8'h00);
    chk("stuff_err_active", 32'(last_active), 32'd1);
    for (int i = 1; i <= 7; i++) begin
      strobe(LS_J, K_NONE, 8'h00);
      if (i == 6) chk("err_active_hold", 32'(last_active), 32'd1);
      if (i == 7) chk("err_active_fall", 32'(last_active), 32'd0);
    end
    line_lvl = LS_J;

    // Short SYNC (3 zeros), recovery, then a good packet.
    send_idle(2);
    strobe(LS_K, K_NONE, 8'h00);
    strobe(LS_J, K_NONE, 8'h00);
    strobe(LS_K, K_NONE, 8'h00);
    strobe(LS_K, K_ERR, 8'h00);
    chk("short_sync_active", 32'(last_active), 32'd0);
    send_idle(7);
    send_sync();
    send_byte(8'h3C);
    send_eop(1'b0);

    // Partial byte at EOP.
    send_idle(2);
    send_sync();
    send_byte(8'h12);
    send_nrzi(1'b1, K_NONE, 8'h00);
    send_nrzi(1'b0, K_NONE, 8'h00);
    send_nrzi(1'b1, K_NONE, 8'h00);
    send_eop(1'b1);

    // Disable mid-byte, traffic while disabled, then a good packet.
    send_idle(2);
    send_sync();
    send_nrzi(1'b0, K_NONE, 8'h00);
    send_nrzi(1'b1, K_NONE, 8'h00);
    send_nrzi(1'b0, K_NONE, 8'h00);
    enable = 1'b0;
    @(negedge clk);
    chk("disable_active", 32'(rx_active), 32'd0);
    strobe(LS_K, K_NONE, 8'h00);
    strobe(LS_SE1, K_NONE, 8'h00);
    strobe(LS_SE0, K_NONE, 8'h00);
    strobe(LS_J, K_NONE, 8'h00);
    enable = 1'b1;
    send_idle(2);
    send_sync();
    send_byte(8'h5A);
    send_eop(1'b0);

    // Reset mid-packet.
    send_idle(2);
    send_sync();
    for (int i = 0; i < 4; i++) send_nrzi(1'b1, K_NONE, 8'h00);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_active", 32'(rx_active), 32'd0);
    chk("midreset_data", 32'(rx_data), 32'd0);
    reset = 1'b0;
    send_idle(3);
    send_sync();
    send_byte(8'hC3);
    send_eop(1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_ls_rx_seq.md
Name: usb_ls_rx_seq

Overview:
Receive-side packet sequencer for the low-speed (1.5 Mb/s) front end. It consumes retimed line states and the per-bit strobe from the clock and data recovery stage, then performs NRZI decoding, SYNC detection, bit unstuffing, byte assembly and EOP/error sequencing. It delivers bytes upstream as single-cycle valid pulses. The bus gives no backpressure, so there is no ready input.

Parameters:
SYNC_ZEROS_MIN, 5, minimum decoded zeros before the terminating 1 for a SYNC to be accepted
STUFF_LEN, 6, consecutive decoded ones after which a stuffed 0 is mandatory
IDLE_BITS, 7, consecutive J bit-times required to leave ERROR

Ports:
clk  in  1  system clock, 24 MHz
reset  in  1  synchronous, active-high
enable  in  1  receiver enable; low forces IDLE
rx_q  in  types::d_port_t  retimed line state (J/K/SE0/SE1)
rx_strobe  in  1  one-clk pulse per bit-time; rx_q is valid in that cycle
rx_data  out  8  received byte, LSB first on the wire
rx_valid  out  1  one-clk pulse, rx_data valid
rx_active  out  1  packet in progress (SYNC accepted, EOP/abort not yet completed)
rx_error  out  1  one-clk pulse on any protocol error

Behaviour:
- Reset values: state=IDLE, prev line state=J, rx_data=0, rx_valid=0, rx_active=0, rx_error=0, all counters=0.
- State and counters advance only in cycles with rx_strobe=1. rx_valid and rx_error are registered and pulse in the clk cycle after the causing strobe. They are 0 otherwise.
- NRZI decoding, J/K only: decoded bit=1 if rx_q equals the previous J/K state, else 0. The previous state updates on every strobe where rx_q is J or K.
- SE1 on any strobe, in any state other than IDLE: go to ERROR.
- IDLE:
  - rx_q=J: stay.
  - rx_q=K: go to SYNC with zero count=1.
  - SE0: stay.
  - The previous-state register is forced to J on the IDLE→SYNC transition, so the first K decodes as 0.
- SYNC:
  - Decoded 0: increment zero count, saturating at 7.
  - Decoded 1 with count ≥ SYNC_ZEROS_MIN: go to DATA, set rx_active=1, clear the ones count and bit count.
  - Decoded 1 with count < SYNC_ZEROS_MIN: go to ERROR.
  - SE0: go to ERROR.
- DATA:
  - If the ones count equals STUFF_LEN, the current bit is the stuff bit:
    - Decoded 0: discard it and clear the ones count.
    - Decoded 1: stuff error, go to ERROR.
  - Otherwise, shift the bit into bit 7 of an 8-bit shift register (LSB first). Increment the ones count on 1 and clear it on 0. Increment the 3-bit bit count.
  - When the 8th bit is shifted: rx_data takes the full byte, rx_valid pulses, bit count wraps to 0.
  - SE0: go to EOP. If bit count ≠0 at that point, pulse rx_error (partial byte); the partial byte is dropped.
- EOP:
  - SE0: stay; an SE0 counter saturates at 3.
  - J: go to IDLE and set rx_active=0.
  - K: go to ERROR.
- ERROR:
  - Pulse rx_error on entry, once only.
  - Count consecutive J strobes; any non-J clears the count.
  - At IDLE_BITS: go to IDLE, set rx_active=0, set prev=J.
- enable=0 (sampled every clk, priority below reset):
  - Force IDLE and rx_active=0; clear the counters.
  - No rx_valid/rx_error pulses are generated. A pulse already registered still completes in the following cycle.
- Reset mid-packet: outputs return to reset values on the next clk. No pulse is emitted.
- A byte completing on the same strobe that would also flag an error is impossible: the error and the byte-completing shift are on different bits.

Test Plan:
- Idle J strobes, then KJKJKJKK, then NRZI of 0xA5 (bits 1,0,1,0,0,1,0,1), then SE0,SE0,J → rx_active rises 1 clk after the 8th SYNC strobe; one rx_valid with rx_data=0xA5; rx_active falls 1 clk after the J strobe; rx_error never asserted.
- SYNC, then bytes 0xFF,0x00 with a stuffed 0 after the 6th one, then EOP → rx_valid twice with 0xFF then 0x00; no error; total data strobes = 17.
- SYNC, then seven consecutive decoded ones → rx_error pulses once 1 clk after the 7th-one strobe; rx_active stays 1 until 7 J strobes later, then 0; no rx_valid.
- SYNC with only 3 zeros before the 1 (K,J,K,K) → rx_error pulse, rx_active never rises; after 7 J strobes, a valid SYNC plus 0x3C is received correctly.
- SYNC, 0x12, 3 extra bits, then SE0,SE0,J → rx_valid with 0x12, then rx_error pulse at the SE0 strobe; returns to IDLE.
- Deassert enable mid-byte, reassert it, then send a full packet with 0x5A → no pulses during the disabled period; rx_active=0 within 1 clk of disable; 0x5A received correctly afterwards.
